// File: rtl/switch_trigger_gen.sv
// Pushbutton front end: two-flop synchronizer, one-hot press/release debounce FSM,
// and a registered light level that toggles once per accepted press.
module switch_trigger_gen #(
    parameter int DEBOUNCE = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_raw,
    input  logic             force_off,
    output logic             trigger,
    output logic [1:0]       level_state,
    output logic             press_pulse,
    output logic             busy,
    output logic [3:0]       fsm_state
);

    typedef enum logic [3:0] {
        IDLE       = 4'b0001,
        PRESS_WAIT = 4'b0010,
        HELD       = 4'b0100,
        REL_WAIT   = 4'b1000
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    logic             sync1;
    logic             btn_s;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             trigger_q;
    logic             trigger_d;
    logic             pulse_q;
    logic             pulse_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1     <= 1'b0;
            btn_s     <= 1'b0;
            state_q   <= IDLE;
            count_q   <= '0;
            trigger_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            sync1     <= btn_raw;
            btn_s     <= sync1;
            state_q   <= state_d;
            count_q   <= count_d;
            trigger_q <= trigger_d;
            pulse_q   <= pulse_d;
        end
    end

    // The count only advances while it is below CNT_MAX, so it can never wrap.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        trigger_d = trigger_q;
        pulse_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                    count_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (count_q == CNT_MAX) begin
                    state_d   = HELD;
                    trigger_d = ~trigger_q;
                    pulse_d   = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d = REL_WAIT;
                    count_d = '0;
                end
            end
            REL_WAIT: begin
                if (btn_s) begin
                    state_d = HELD;
                end else if (count_q == CNT_MAX) begin
                    state_d = IDLE;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
        // force_off wins over a same-edge toggle but leaves the pulse and FSM alone.
        if (force_off) begin
            trigger_d = 1'b0;
        end
    end

    assign trigger     = trigger_q;
    assign level_state = {trigger_q, ~trigger_q};
    assign press_pulse = pulse_q;
    assign busy        = ~state_q[0];
    assign fsm_state   = state_q;

endmodule

// File: doc/switch_trigger_gen.md
Name: switch_trigger_gen

Overview:
Front-end conditioner that produces the `trigger` level consumed by the light-switch FSM.
- Takes a raw momentary pushbutton and synchronizes it into the clock domain.
- Debounces both press and release with a one-hot state machine.
- On each accepted press, toggles a registered FlipUp/FlipDown level and emits a one-cycle press pulse.
- Sits between the board pushbutton and the light-switch FSM's `trigger` input.

Parameters:
DEBOUNCE, 16, cycles the synchronized input must hold stable for a press or release to be accepted (legal range 2..2**CNT_W).
CNT_W, 8, debounce counter width; must satisfy 2**CNT_W >= DEBOUNCE.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset; asynchronous, active-low (0 = reset)
btn_raw  input  1  raw pushbutton, asynchronous, 1 = pressed
force_off  input  1  synchronous clear of the light level, sampled every cycle
trigger  output  1  registered light level: 0 = FlipDown, 1 = FlipUp
level_state  output  2  one-hot mirror of trigger: 2'b01 = Off, 2'b10 = On
press_pulse  output  1  one-cycle high on each accepted press
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst = 0), immediate and independent of clk:
  - sync1 = sync2 = 0, FSM = IDLE, count = 0.
  - trigger = 0, level_state = 2'b01, press_pulse = 0, busy = 0.
  - Reset mid-debounce abandons the press; no toggle occurs.
- Synchronizer: two flops, btn_raw -> sync1 -> sync2. Call sync2 btn_s. The FSM uses only btn_s.
- FSM, one-hot, 4 bits: IDLE = 4'b0001, PRESS_WAIT = 4'b0010, HELD = 4'b0100, REL_WAIT = 4'b1000.
  - IDLE: if btn_s = 1, go to PRESS_WAIT and set count = 0.
  - PRESS_WAIT:
    - If btn_s = 0, go to IDLE and set count = 0 (bounce rejected, no pulse).
    - Else if count == DEBOUNCE-1, go to HELD, toggle trigger, press_pulse = 1 for exactly that cycle.
    - Else count = count + 1.
  - HELD: if btn_s = 0, go to REL_WAIT and set count = 0. A held button never re-triggers.
  - REL_WAIT:
    - If btn_s = 1, go back to HELD (release bounce, no pulse).
    - Else if count == DEBOUNCE-1, go to IDLE.
    - Else count = count + 1.
  - Illegal or non-one-hot state: go to IDLE on the next edge with count = 0; trigger unchanged.
- Timing:
  - PRESS_WAIT and REL_WAIT each last exactly DEBOUNCE cycles when the input is clean.
  - Let E0 be the first rising edge that samples btn_raw = 1. btn_s rises at E1, the FSM enters PRESS_WAIT at E2, and trigger toggles at edge E(2+DEBOUNCE).
  - press_pulse is high from that edge until the next edge.
- Outputs:
  - trigger, press_pulse and level_state are registered; no combinational path from inputs.
  - level_state is always {trigger, ~trigger}.
  - busy = ~state[0].
- force_off:
  - When sampled high, trigger becomes 0 on that edge, in any state.
  - FSM state and count are unaffected.
  - If force_off and press acceptance fall on the same edge: trigger = 0, press_pulse = 1, FSM goes to HELD.
- Count: never exceeds DEBOUNCE-1; no wrap is possible.

Test Plan:
Reset sanity: DEBOUNCE = 4; hold rst = 0 for 3 cycles, then release -> trigger = 0, level_state = 01, press_pulse = 0, busy = 0, state = 0001.
Clean press: btn_raw = 1 from E0 and held 20 cycles -> busy rises after E2, trigger 0->1 and press_pulse = 1 only at E6, level_state = 10, no further toggles while held.
Press bounce: btn_raw pattern 1,1,0,1,1,1,1 then held -> only the final stable run is accepted; exactly one press_pulse, trigger toggles once.
Release bounce and second press: after Clean press, drop btn_raw to 0, pulse it to 1 for 1 cycle during REL_WAIT, then stay 0 for 10 cycles, then press cleanly again -> no extra toggle during release; the second press sets trigger 1->0, level_state = 01.
Force_off collision: drive force_off = 1 on exactly the press-acceptance edge with trigger = 0 -> trigger stays 0, press_pulse = 1, FSM = 0100. Then force_off = 1 while in HELD with trigger = 1 -> trigger = 0 next edge, state unchanged.
Async reset mid-debounce: assert rst = 0 mid-clock, 2 cycles into PRESS_WAIT -> outputs clear immediately without waiting for a clock edge; after release with btn_raw = 1, the full 2+DEBOUNCE latency restarts from the first sampling edge.
